// File: rtl/tmnt_io_pkg.sv
// Shared register map and helpers for the 68000-side system I/O controller.
package tmnt_io_pkg;

    localparam logic [3:0] CTRL = 4'd0;
    localparam logic [3:0] SND  = 4'd1;
    localparam logic [3:0] WDOG = 4'd2;
    localparam logic [3:0] PRI  = 4'd3;
    localparam logic [3:0] SYS  = 4'd8;
    localparam logic [3:0] P1   = 4'd9;
    localparam logic [3:0] DSW1 = 4'd12;
    localparam logic [3:0] DSW2 = 4'd13;
    localparam logic [3:0] DSW3 = 4'd14;
    localparam logic [3:0] STAT = 4'd15;

    function automatic logic [2:0] ipl_encode(input logic [2:0] level);
        return ~level;
    endfunction

endpackage

// File: rtl/sys_io_ctrl_coin_pulse.sv
// One coin-counter channel: timed pulse from a write strobe, or a plain latch when PULSE = 0.
module coin_pulse #(
    parameter int unsigned PULSE = 16384
) (
    input  logic clk,
    input  logic rst_n,
    input  logic wr,
    input  logic bit_in,
    output logic ctr
);

    generate
        if (PULSE == 0) begin : g_level
            logic lvl_q, lvl_d;

            always_comb begin
                lvl_d = lvl_q;
                if (wr) lvl_d = bit_in;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) lvl_q <= 1'b0;
                else        lvl_q <= lvl_d;
            end

            assign ctr = lvl_q;
        end else begin : g_pulse
            localparam int CW = $clog2(PULSE + 1);
            logic [CW-1:0] cnt_q, cnt_d;

            // A written 1 (re)starts the pulse; a written 0 lets it run out.
            always_comb begin
                cnt_d = cnt_q;
                if (wr && bit_in)     cnt_d = CW'(PULSE);
                else if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) cnt_q <= '0;
                else        cnt_q <= cnt_d;
            end

            assign ctr = (cnt_q != '0);
        end
    endgenerate

endmodule

// File: rtl/sys_io_ctrl.sv
// 68000 system I/O: control latches, vblank IRQ, coin counters, watchdog,
// sound-command latch and the input read mux with DTACK.
module sys_io_ctrl
    import tmnt_io_pkg::*;
#(
    parameter int unsigned PLAYERS     = 4,
    parameter int unsigned IRQ_LEVEL   = 5,
    parameter int unsigned IRQ_AUTOACK = 0,
    parameter int unsigned COIN_PULSE  = 16384,
    parameter int unsigned WDT_BITS    = 20
) (
    input  logic                   clk_main,
    input  logic                   nRESET,
    input  logic                   io_cs_n,
    input  logic                   rw,
    input  logic [3:0]             addr,
    input  logic [7:0]             din,
    output logic [7:0]             dout,
    output logic                   dtack_n,
    input  logic                   vblank,
    input  logic                   iack,
    output logic [2:0]             ipl_n,
    input  logic [8*PLAYERS-1:0]   p_in,
    input  logic [7:0]             sys_in,
    input  logic [19:0]            dsw,
    output logic                   rmrd,
    output logic                   int_en,
    output logic                   sndon,
    output logic [1:0]             pri,
    output logic [1:0]             coin_ctr,
    output logic [7:0]             snd_data,
    output logic                   snd_irq,
    input  logic                   snd_ack,
    output logic                   wd_reset_n
);

    // Players beyond the third alias DSW1 in the map, so at most three are readable.
    localparam int unsigned NP = (PLAYERS < 3) ? PLAYERS : 3;

    logic       cs_q, vb_q, dtack_n_q, rmrd_q, int_en_q, sndon_q, snd_pend_q, irq_q;
    logic       cs_d, vb_d, dtack_n_d, rmrd_d, int_en_d, sndon_d, snd_pend_d, irq_d;
    logic [7:0] dout_q, dout_d, snd_data_q, snd_data_d, rd_data;
    logic [1:0] pri_q, pri_d;
    logic       start, wr_ctrl, wr_snd, wr_wdog, wr_pri, rd_en;

    // Fourth player byte is unreachable through the map.
    logic unused_p;
    assign unused_p = ^p_in;

    assign start   = cs_q & ~io_cs_n;
    assign rd_en   = start & rw;
    assign wr_ctrl = start & ~rw & (addr == CTRL);
    assign wr_snd  = start & ~rw & (addr == SND);
    assign wr_wdog = start & ~rw & (addr == WDOG);
    assign wr_pri  = start & ~rw & (addr == PRI);

    always_comb begin
        rd_data = 8'h00;
        case (addr)
            SYS:                        rd_data = sys_in;
            P1, P1 + 4'd1, P1 + 4'd2:   rd_data = 8'hFF;
            DSW1:                       rd_data = dsw[7:0];
            DSW2:                       rd_data = dsw[15:8];
            DSW3:                       rd_data = {4'h0, dsw[19:16]};
            STAT:                       rd_data = {7'h0, snd_pend_q};
            default:                    rd_data = 8'h00;
        endcase
        for (int i = 0; i < int'(NP); i++)
            if (addr == P1 + 4'(i)) rd_data = p_in[i*8 +: 8];
    end

    always_comb begin
        cs_d       = io_cs_n;
        vb_d       = vblank;
        dout_d     = rd_en ? rd_data : dout_q;
        dtack_n_d  = dtack_n_q;
        rmrd_d     = rmrd_q;
        int_en_d   = int_en_q;
        sndon_d    = sndon_q;
        pri_d      = pri_q;
        snd_data_d = snd_data_q;
        snd_pend_d = snd_pend_q;
        irq_d      = irq_q;

        if (io_cs_n)    dtack_n_d = 1'b1;
        else if (start) dtack_n_d = 1'b0;

        if (wr_ctrl) begin
            rmrd_d   = din[7];
            int_en_d = din[5];
            sndon_d  = din[3];
        end
        if (wr_pri) pri_d = din[3:2];

        // A new command overrides an acknowledge arriving in the same clock.
        if (wr_snd) begin
            snd_data_d = din;
            snd_pend_d = 1'b1;
        end else if (snd_ack) begin
            snd_pend_d = 1'b0;
        end

        // Set is evaluated last so a simultaneous vblank edge beats any clear.
        if (wr_ctrl && !din[5])          irq_d = 1'b0;
        if (IRQ_AUTOACK != 0 && iack)    irq_d = 1'b0;
        if (vblank && !vb_q && int_en_q) irq_d = 1'b1;
    end

    always_ff @(posedge clk_main or negedge nRESET) begin
        if (!nRESET) begin
            cs_q       <= 1'b1;
            vb_q       <= 1'b1;
            dout_q     <= 8'h00;
            dtack_n_q  <= 1'b1;
            rmrd_q     <= 1'b0;
            int_en_q   <= 1'b0;
            sndon_q    <= 1'b0;
            pri_q      <= 2'b00;
            snd_data_q <= 8'h00;
            snd_pend_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            cs_q       <= cs_d;
            vb_q       <= vb_d;
            dout_q     <= dout_d;
            dtack_n_q  <= dtack_n_d;
            rmrd_q     <= rmrd_d;
            int_en_q   <= int_en_d;
            sndon_q    <= sndon_d;
            pri_q      <= pri_d;
            snd_data_q <= snd_data_d;
            snd_pend_q <= snd_pend_d;
            irq_q      <= irq_d;
        end
    end

    assign dout     = dout_q;
    assign dtack_n  = dtack_n_q;
    assign rmrd     = rmrd_q;
    assign int_en   = int_en_q;
    assign sndon    = sndon_q;
    assign pri      = pri_q;
    assign snd_data = snd_data_q;
    assign snd_irq  = snd_pend_q;
    assign ipl_n    = irq_q ? ipl_encode(3'(IRQ_LEVEL)) : 3'b111;

    for (genvar c = 0; c < 2; c++) begin : g_coin
        coin_pulse #(.PULSE(COIN_PULSE)) u_coin (
            .clk    (clk_main),
            .rst_n  (nRESET),
            .wr     (wr_ctrl),
            .bit_in (din[c]),
            .ctr    (coin_ctr[c])
        );
    end

    generate
        if (WDT_BITS > 0) begin : g_wdt
            logic [WDT_BITS-1:0] wcnt_q, wcnt_d;
            logic [3:0]          wlow_q, wlow_d;
            logic                wd_n_q, wd_n_d;

            // While the reset request is out the counter is frozen and kicks are ignored.
            always_comb begin
                wcnt_d = wcnt_q;
                wlow_d = wlow_q;
                wd_n_d = wd_n_q;
                if (!wd_n_q) begin
                    wlow_d = wlow_q + 4'd1;
                    if (wlow_q == 4'hF) begin
                        wd_n_d = 1'b1;
                        wcnt_d = '0;
                    end
                end else if (wr_wdog) begin
                    wcnt_d = '0;
                end else if (&wcnt_q) begin
                    wd_n_d = 1'b0;
                    wlow_d = 4'd0;
                end else begin
                    wcnt_d = wcnt_q + WDT_BITS'(1);
                end
            end

            always_ff @(posedge clk_main or negedge nRESET) begin
                if (!nRESET) begin
                    wcnt_q <= '0;
                    wlow_q <= 4'd0;
                    wd_n_q <= 1'b1;
                end else begin
                    wcnt_q <= wcnt_d;
                    wlow_q <= wlow_d;
                    wd_n_q <= wd_n_d;
                end
            end

            assign wd_reset_n = wd_n_q;
        end else begin : g_no_wdt
            logic unused_wdog;
            assign unused_wdog = wr_wdog;
            assign wd_reset_n  = 1'b1;
        end
    endgenerate

endmodule

// File: tb/tb_sys_io_ctrl.sv
// Directed bench for sys_io_ctrl: two instances differing only in IRQ acknowledge mode.
module tb_sys_io_ctrl;

    logic        clk_main = 1'b0;
    logic        nRESET   = 1'b0;
    logic        io_cs_n, rw, vblank, iack, snd_ack;
    logic [3:0]  addr;
    logic [7:0]  din, sys_in;
    logic [15:0] p_in;
    logic [19:0] dsw;

    logic [7:0]  dout, snd_data, dout0, snd_data0;
    logic        dtack_n, rmrd, int_en, sndon, snd_irq, wd_reset_n;
    logic        dtack_n0, rmrd0, int_en0, sndon0, snd_irq0, wd_reset_n0;
    logic [2:0]  ipl_n, ipl_n0;
    logic [1:0]  pri, coin_ctr, pri0, coin_ctr0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_main = ~clk_main;

    sys_io_ctrl #(.PLAYERS(2), .IRQ_LEVEL(5), .IRQ_AUTOACK(1), .COIN_PULSE(8), .WDT_BITS(4)) u_dut (
        .clk_main(clk_main), .nRESET(nRESET), .io_cs_n(io_cs_n), .rw(rw), .addr(addr), .din(din),
        .dout(dout), .dtack_n(dtack_n), .vblank(vblank), .iack(iack), .ipl_n(ipl_n), .p_in(p_in),
        .sys_in(sys_in), .dsw(dsw), .rmrd(rmrd), .int_en(int_en), .sndon(sndon), .pri(pri),
        .coin_ctr(coin_ctr), .snd_data(snd_data), .snd_irq(snd_irq), .snd_ack(snd_ack),
        .wd_reset_n(wd_reset_n)
    );

    sys_io_ctrl #(.PLAYERS(2), .IRQ_LEVEL(5), .IRQ_AUTOACK(0), .COIN_PULSE(8), .WDT_BITS(4)) u_dut0 (
        .clk_main(clk_main), .nRESET(nRESET), .io_cs_n(io_cs_n), .rw(rw), .addr(addr), .din(din),
        .dout(dout0), .dtack_n(dtack_n0), .vblank(vblank), .iack(iack), .ipl_n(ipl_n0), .p_in(p_in),
        .sys_in(sys_in), .dsw(dsw), .rmrd(rmrd0), .int_en(int_en0), .sndon(sndon0), .pri(pri0),
        .coin_ctr(coin_ctr0), .snd_data(snd_data0), .snd_irq(snd_irq0), .snd_ack(snd_ack),
        .wd_reset_n(wd_reset_n0)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        nRESET = 1'b0; io_cs_n = 1'b1; rw = 1'b1; addr = 4'd0; din = 8'h00;
        vblank = 1'b0; iack = 1'b0; snd_ack = 1'b0;
        @(negedge clk_main);
        @(negedge clk_main);
        nRESET = 1'b1;
    endtask

    // Called just after a negedge; one start edge, then one idle edge as the gap.
    task automatic bus_wr(input logic [3:0] a, input logic [7:0] d);
        io_cs_n = 1'b0; rw = 1'b0; addr = a; din = d;
        @(negedge clk_main);
        io_cs_n = 1'b1; rw = 1'b1;
        @(negedge clk_main);
    endtask

    task automatic bus_rd(input logic [3:0] a, output logic [7:0] d);
        io_cs_n = 1'b0; rw = 1'b1; addr = a;
        @(negedge clk_main);
        d = dout;
        io_cs_n = 1'b1;
        @(negedge clk_main);
    endtask

    initial begin
        logic [7:0]  rd;
        logic [63:0] obs, expv;
        int          hi0, hi1;
        logic        low_seen;

        p_in = 16'hC35A; sys_in = 8'h96; dsw = 20'hB7E21;
        do_reset();

        chk("rst_dout", dout, 8'h00);
        chk("rst_dtack", dtack_n, 1'b1);
        chk("rst_ipl", ipl_n, 3'b111);
        chk("rst_ctrl", {rmrd, int_en, sndon, pri, coin_ctr}, 7'b0);
        chk("rst_snd", {snd_data, snd_irq}, 9'h000);
        chk("rst_wd", wd_reset_n, 1'b1);

        // Control write, DTACK timing
        io_cs_n = 1'b0; rw = 1'b0; addr = 4'd0; din = 8'hA8;
        chk("dtack_pre", dtack_n, 1'b1);
        @(negedge clk_main);
        chk("dtack_low", dtack_n, 1'b0);
        chk("ctrl_a8", {rmrd, int_en, sndon}, 3'b111);
        @(negedge clk_main);
        chk("dtack_hold", dtack_n, 1'b0);
        io_cs_n = 1'b1; rw = 1'b1;
        @(negedge clk_main);
        @(negedge clk_main);
        chk("dtack_rel", dtack_n, 1'b1);

        // Vblank interrupt
        vblank = 1'b1;
        @(negedge clk_main);
        vblank = 1'b0;
        chk("irq_set", ipl_n, 3'b010);
        chk("irq_set0", ipl_n0, 3'b010);
        bus_wr(4'd0, 8'h00);
        chk("irq_clr_wr", ipl_n, 3'b111);
        bus_wr(4'd0, 8'h20);
        vblank = 1'b1;
        @(negedge clk_main);
        vblank = 1'b0;
        chk("irq_set2", ipl_n, 3'b010);
        iack = 1'b1;
        @(negedge clk_main);
        iack = 1'b0;
        chk("irq_autoack", ipl_n, 3'b111);
        chk("irq_noack0", ipl_n0, 3'b010);
        vblank = 1'b1;
        bus_wr(4'd0, 8'h00);
        chk("irq_set_wins", ipl_n, 3'b010);
        vblank = 1'b0;
        bus_wr(4'd0, 8'h00);
        chk("irq_clr2", ipl_n, 3'b111);
        chk("irq_clr0", ipl_n0, 3'b111);
        vblank = 1'b1;
        @(negedge clk_main);
        vblank = 1'b0;
        chk("irq_masked", ipl_n, 3'b111);

        // Read mux
        bus_rd(4'd9, rd);  chk("rd_p1", rd, 8'h5A);
        bus_rd(4'd10, rd); chk("rd_p2", rd, 8'hC3);
        bus_rd(4'd11, rd); chk("rd_p3_absent", rd, 8'hFF);
        bus_rd(4'd8, rd);  chk("rd_sys", rd, 8'h96);
        bus_rd(4'd12, rd); chk("rd_dsw1", rd, 8'h21);
        bus_rd(4'd13, rd); chk("rd_dsw2", rd, 8'h7E);
        bus_rd(4'd14, rd); chk("rd_dsw3", rd, 8'h0B);
        bus_rd(4'd5, rd);  chk("rd_unmapped", rd, 8'h00);
        bus_rd(4'd9, rd);
        bus_wr(4'd3, 8'h04);
        chk("dout_hold", dout, 8'h5A);
        chk("pri_wr", pri, 2'b01);

        // Coin pulse: start at edge 0, restart at 5, write 0 at 8
        hi0 = 0; hi1 = 0;
        for (int c = 0; c < 20; c++) begin
            if (c == 0 || c == 5 || c == 8) begin
                io_cs_n = 1'b0; rw = 1'b0; addr = 4'd0; din = (c == 8) ? 8'h00 : 8'h01;
            end else begin
                io_cs_n = 1'b1; rw = 1'b1;
            end
            @(negedge clk_main);
            if (coin_ctr[0]) hi0++;
            if (coin_ctr[1]) hi1++;
        end
        chk("coin0_len", hi0, 13);
        chk("coin1_idle", hi1, 0);

        // Sound latch: write beats a same-cycle ack
        io_cs_n = 1'b0; rw = 1'b0; addr = 4'd1; din = 8'h42; snd_ack = 1'b1;
        @(negedge clk_main);
        snd_ack = 1'b0; io_cs_n = 1'b1; rw = 1'b1;
        @(negedge clk_main);
        chk("snd_data", snd_data, 8'h42);
        chk("snd_irq_set", snd_irq, 1'b1);
        bus_rd(4'd15, rd); chk("rd_stat1", rd, 8'h01);
        snd_ack = 1'b1;
        @(negedge clk_main);
        snd_ack = 1'b0;
        chk("snd_irq_ack", snd_irq, 1'b0);
        bus_rd(4'd15, rd); chk("rd_stat0", rd, 8'h00);

        // Reset during an access discards it
        io_cs_n = 1'b0; rw = 1'b0; addr = 4'd3; din = 8'h0C; nRESET = 1'b0;
        @(negedge clk_main);
        io_cs_n = 1'b1; rw = 1'b1;
        @(negedge clk_main);
        nRESET = 1'b1;
        @(negedge clk_main);
        chk("rst_abort_pri", pri, 2'b00);
        chk("rst_abort_dtack", dtack_n, 1'b1);
        bus_wr(4'd3, 8'h0C);
        chk("pri_after", pri, 2'b11);

        // Watchdog, no effective kicks (one inside the low window)
        do_reset();
        obs = '0; expv = '0;
        for (int c = 0; c < 64; c++) begin
            if (c == 20) begin
                io_cs_n = 1'b0; rw = 1'b0; addr = 4'd2;
            end else begin
                io_cs_n = 1'b1; rw = 1'b1;
            end
            @(negedge clk_main);
            obs[c]  = ~wd_reset_n;
            expv[c] = (c >= 15 && c <= 30) || (c >= 47 && c <= 62);
        end
        chk("wdt_pattern", obs, expv);

        // Watchdog kicked every 10 clocks
        do_reset();
        low_seen = 1'b0;
        for (int c = 0; c < 80; c++) begin
            if (c % 10 == 5) begin
                io_cs_n = 1'b0; rw = 1'b0; addr = 4'd2;
            end else begin
                io_cs_n = 1'b1; rw = 1'b1;
            end
            @(negedge clk_main);
            low_seen = low_seen | ~wd_reset_n;
        end
        chk("wdt_kicked", low_seen, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
